fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage that holds the control unit. It owns the PC, issues word fetches to instruction memory over a request/grant/response handshake, buffers returned words in a small prefetch FIFO, and presents one instruction per cycle on the IF/ID register. It honours decode freeze and execute-stage branch redirects.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage_fifo.sv | 55 +++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared MIPS pipeline definitions used by the fetch stage and its prefetch FIFO.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } fetch_state_e;

  // One IF/ID payload: pc is the instruction address + 4.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/response bus between fetch and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage_fifo.sv
// Prefetch FIFO of {pc,instr} pairs; flush wins over push/pop, push allowed when full if popping.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  ifid_t            i_data,
  output ifid_t            o_data,
  output logic [CNT_W-1:0] o_count
);

  ifid_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);
  assign o_data    = r_mem[r_rd];
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem fetch, prefetch FIFO, IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 br_taken,
  input  logic [31:0]          br_addr,
  fetch_stage_if.master        imem,
  output logic                 if_valid,
  output logic [31:0]          if_instr,
  output logic [31:0]          if_pc
);

  fetch_state_e         r_state;
  fetch_state_e         w_state_nxt;
  logic [31:0]          r_pc;
  logic                 r_outstanding;
  logic                 r_if_valid;
  logic [31:0]          r_if_instr;
  logic [31:0]          r_if_pc;

  logic [$clog2(DEPTH):0] w_fifo_count;
  ifid_t                w_fifo_head;
  ifid_t                w_rsp_data;
  logic                 w_rsp;
  logic                 w_rsp_keep;
  logic                 w_load;
  logic                 w_fifo_empty;
  logic                 w_bypass;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_pend;
  logic                 w_room;
  logic                 w_req;
  logic                 w_gnt;

  assign w_rsp        = r_outstanding && imem.imem_rvalid;
  assign w_rsp_keep   = w_rsp && (r_state == ST_RUN) && !br_taken;
  assign w_load       = !freeze || !r_if_valid;
  assign w_fifo_empty = (w_fifo_count == '0);
  assign w_bypass     = w_rsp_keep && w_fifo_empty && w_load;
  assign w_push       = w_rsp_keep && !w_bypass;
  assign w_pop        = w_load && !w_fifo_empty && !br_taken;
  // The in-flight response needs a FIFO slot unless it lands straight in IF/ID or is
  // being dropped; reserving it here is what keeps a frozen, filling FIFO lossless.
  assign w_pend       = r_outstanding && (!imem.imem_rvalid || w_push);
  assign w_room       = (int'(w_fifo_count) + int'(w_pend)) < DEPTH;
  assign w_gnt        = w_req && imem.imem_gnt;

  // PC only moves on grant, so while one request is in flight it equals that request + 4.
  assign w_rsp_data   = '{pc: r_pc, instr: imem.imem_rdata};

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    if (br_taken) begin
      w_state_nxt = (r_outstanding && !imem.imem_rvalid) ? ST_DROP : ST_RUN;
    end else begin
      if (r_state == ST_DROP && w_rsp) w_state_nxt = ST_RUN;
      w_req = (!r_outstanding || imem.imem_rvalid) && w_room;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= 1'b0;
    end else begin
      if (br_taken)   r_pc <= align_word(br_addr);
      else if (w_gnt) r_pc <= r_pc + PC_STEP;
      if (w_gnt)                 r_outstanding <= 1'b1;
      else if (imem.imem_rvalid) r_outstanding <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= '0;
    end else if (br_taken) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end else if (w_load) begin
      if (!w_fifo_empty) begin
        r_if_valid <= 1'b1;
        r_if_instr <= w_fifo_head.instr;
        r_if_pc    <= w_fifo_head.pc;
      end else if (w_bypass) begin
        r_if_valid <= 1'b1;
        r_if_instr <= w_rsp_data.instr;
        r_if_pc    <= w_rsp_data.pc;
      end else begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP_INSTR;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (br_taken),
    .i_data  (w_rsp_data),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count)
  );

endmodule
